// File: rtl/edge_setup.sv
// Per-frame triangle setup: latches three vertices at (480,0), computes column-0 edge values
// with a shared shift-add multiplier, then steps them per line. Option: EDGE_SETUP_CULL_EN (back-face cull).
module edge_setup (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               vtx_valid,
  input  logic signed [10:0] vtx_x0,
  input  logic signed [10:0] vtx_x1,
  input  logic signed [10:0] vtx_x2,
  input  logic signed [10:0] vtx_y0,
  input  logic signed [10:0] vtx_y1,
  input  logic signed [10:0] vtx_y2,
  output logic signed [19:0] y_screen_v0,
  output logic signed [19:0] y_screen_v1,
  output logic signed [19:0] y_screen_v2,
  output logic signed [19:0] e0_init_t1,
  output logic signed [19:0] e1_init_t1,
  output logic signed [19:0] e2_init_t1,
  output logic               setup_busy
);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_DELTA, S_MUL, S_SUM, S_LOAD} state_t;

`ifdef EDGE_SETUP_CULL_EN
  localparam int NUM_PROD = 8;
`else
  localparam int NUM_PROD = 6;
`endif
  localparam logic [2:0] LAST_PROD = 3'(NUM_PROD - 1);

  state_t state, state_next;

  logic signed [10:0] sx [3];
  logic signed [10:0] sy [3];
  logic signed [11:0] da [3];
  logic signed [11:0] db [3];
  logic [19:0] prod [NUM_PROD];
  logic [19:0] sum [3];
  logic [19:0] e_init [3];
  logic [19:0] ys [3];
  logic [19:0] d_step [3];
`ifdef EDGE_SETUP_CULL_EN
  logic [19:0] area;
`endif

  logic [23:0] acc, acc_next, partial;
  logic [3:0]  bit_cnt;
  logic [2:0]  prod_idx;
  logic [11:0] op_a, op_b, mag_a, mag_b;
  logic        flip, neg;
  logic [19:0] prod_val;
  logic        latch_pt, step_pt, mul_last;

  assign latch_pt = (y == 10'd480) && (x == 10'd0);
  assign step_pt  = (x == 10'd799) && ((y == 10'd524) || (y < 10'd479));
  assign mul_last = (bit_cnt == 4'd11);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (latch_pt) state_next = S_LATCH;
      S_LATCH: state_next = S_DELTA;
      S_DELTA: state_next = S_MUL;
      S_MUL:   if (mul_last && (prod_idx == LAST_PROD)) state_next = S_SUM;
      S_SUM:   state_next = S_LOAD;
      S_LOAD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    setup_busy = (state != S_IDLE);
  end

  // Product schedule: x_k*A_k, then y_k*B_k, then the two area terms written as -(B2*A0), -(A2*B0)
  always_comb begin
    op_a = '0;
    op_b = '0;
    flip = 1'b0;
    case (prod_idx)
      3'd0: begin op_a = {sx[0][10], sx[0]}; op_b = da[0]; end
      3'd1: begin op_a = {sx[1][10], sx[1]}; op_b = da[1]; end
      3'd2: begin op_a = {sx[2][10], sx[2]}; op_b = da[2]; end
      3'd3: begin op_a = {sy[0][10], sy[0]}; op_b = db[0]; end
      3'd4: begin op_a = {sy[1][10], sy[1]}; op_b = db[1]; end
      3'd5: begin op_a = {sy[2][10], sy[2]}; op_b = db[2]; end
`ifdef EDGE_SETUP_CULL_EN
      3'd6: begin op_a = db[2]; op_b = da[0]; flip = 1'b1; end
      3'd7: begin op_a = da[2]; op_b = db[0]; flip = 1'b1; end
`endif
      default: ;
    endcase
    mag_a    = op_a[11] ? (12'd0 - op_a) : op_a;
    mag_b    = op_b[11] ? (12'd0 - op_b) : op_b;
    neg      = op_a[11] ^ op_b[11] ^ flip;
    partial  = mag_b[bit_cnt] ? ({12'd0, mag_a} << bit_cnt) : 24'd0;
    acc_next = acc + partial;
    prod_val = neg ? (20'd0 - acc_next[19:0]) : acc_next[19:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        sx[k] <= '0; sy[k] <= '0; da[k] <= '0; db[k] <= '0;
        sum[k] <= '0; e_init[k] <= '0; ys[k] <= '0; d_step[k] <= '0;
      end
      for (int i = 0; i < NUM_PROD; i++) prod[i] <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      prod_idx <= '0;
`ifdef EDGE_SETUP_CULL_EN
      area     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (latch_pt) begin
            if (vtx_valid) begin
              sx[0] <= vtx_x0; sx[1] <= vtx_x1; sx[2] <= vtx_x2;
              sy[0] <= vtx_y0; sy[1] <= vtx_y1; sy[2] <= vtx_y2;
            end
          end else if (step_pt) begin
            for (int k = 0; k < 3; k++) e_init[k] <= e_init[k] - d_step[k];
          end
        end
        S_LATCH: begin
          for (int k = 0; k < 3; k++) begin
            da[k] <= {sy[(k+1)%3][10], sy[(k+1)%3]} - {sy[k][10], sy[k]};
            db[k] <= {sx[(k+1)%3][10], sx[(k+1)%3]} - {sx[k][10], sx[k]};
          end
        end
        S_DELTA: begin
          acc      <= '0;
          bit_cnt  <= '0;
          prod_idx <= '0;
        end
        S_MUL: begin
          if (mul_last) begin
            prod[prod_idx] <= prod_val;
            acc            <= '0;
            bit_cnt        <= '0;
            prod_idx       <= prod_idx + 3'd1;
          end else begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_SUM: begin
          for (int k = 0; k < 3; k++) sum[k] <= prod[3+k] - prod[k];
`ifdef EDGE_SETUP_CULL_EN
          area <= prod[6] - prod[7];
`endif
        end
        S_LOAD: begin
          for (int k = 0; k < 3; k++) begin
            e_init[k] <= sum[k];
            ys[k]     <= {{9{sy[k][10]}}, sy[k]};
            d_step[k] <= {{8{db[k][11]}}, db[k]};
`ifdef EDGE_SETUP_CULL_EN
            // Clockwise or degenerate: every edge reads outside, nothing steps
            if (area[19] || (area == 20'd0)) begin
              e_init[k] <= 20'hFFFFF;
              ys[k]     <= '0;
              d_step[k] <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign e0_init_t1  = e_init[0];
  assign e1_init_t1  = e_init[1];
  assign e2_init_t1  = e_init[2];
  assign y_screen_v0 = ys[0];
  assign y_screen_v1 = ys[1];
  assign y_screen_v2 = ys[2];

endmodule

// File: tb/tb_edge_setup.sv
// Bench for edge_setup: directed frames with hand-computed edge values, queue scoreboard,
// monitor checking on setup completion and on explicit sample requests.
module tb_edge_setup;

`ifdef EDGE_SETUP_CULL_EN
  localparam int EXP_BUSY = 100;
`else
  localparam int EXP_BUSY = 76;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [9:0] x, y;
  logic vtx_valid;
  logic signed [10:0] vtx_x0, vtx_x1, vtx_x2, vtx_y0, vtx_y1, vtx_y2;
  logic signed [19:0] y_screen_v0, y_screen_v1, y_screen_v2;
  logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
  logic setup_busy;

  edge_setup dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .vtx_valid(vtx_valid),
    .vtx_x0(vtx_x0), .vtx_x1(vtx_x1), .vtx_x2(vtx_x2),
    .vtx_y0(vtx_y0), .vtx_y1(vtx_y1), .vtx_y2(vtx_y2),
    .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1), .y_screen_v2(y_screen_v2),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .setup_busy(setup_busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state: {e0,e1,e2,ys0,ys1,ys2,busy}
  logic [120:0] exp_q[$];
  string        name_q[$];
  logic chk_req  = 1'b0;
  logic to_req   = 1'b0;
  logic done_req = 1'b0;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [120:0] pk(input int e0, input int e1, input int e2,
                                      input int y0, input int y1, input int y2, input logic b);
    pk = {20'(e0), 20'(e1), 20'(e2), 20'(y0), 20'(y1), 20'(y2), b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
    to_req  = 1'b0;
  endtask

  task automatic park();
    x = 10'd1;
    y = 10'd200;
  endtask

  task automatic expect_now(input logic [120:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_req = 1'b1;
    tick();
  endtask

  task automatic do_step(input int ln);
    x = 10'd799;
    y = 10'(ln);
    tick();
    park();
  endtask

  task automatic latch_start(input logic v, input int ax0, input int ay0, input int ax1,
                             input int ay1, input int ax2, input int ay2);
    x = 10'd0;
    y = 10'd480;
    vtx_valid = v;
    vtx_x0 = 11'(ax0); vtx_y0 = 11'(ay0);
    vtx_x1 = 11'(ax1); vtx_y1 = 11'(ay1);
    vtx_x2 = 11'(ax2); vtx_y2 = 11'(ay2);
    tick();
    x = 10'd1;
    vtx_valid = 1'($urandom_range(1, 0));
    vtx_x0 = 11'($urandom_range(2047, 0)); vtx_y0 = 11'($urandom_range(2047, 0));
    vtx_x1 = 11'($urandom_range(2047, 0)); vtx_y1 = 11'($urandom_range(2047, 0));
    vtx_x2 = 11'($urandom_range(2047, 0)); vtx_y2 = 11'($urandom_range(2047, 0));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (setup_busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) to_req = 1'b1;
    park();
    tick();
  endtask

  task automatic run_frame(input logic v, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int ax2, input int ay2,
                           input logic [120:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    latch_start(v, ax0, ay0, ax1, ay1, ax2, ay2);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [120:0] eb, eb_s, ed, ed_s;
    reset = 1'b1;
    vtx_valid = 1'b0;
    vtx_x0 = '0; vtx_x1 = '0; vtx_x2 = '0;
    vtx_y0 = '0; vtx_y1 = '0; vtx_y2 = '0;
    park();
    repeat (3) tick();
    expect_now(pk(0, 0, 0, 0, 0, 0, 1'b0), "reset");
    reset = 1'b0;
    tick();
    do_step(10);
    x = 10'd0; y = 10'd479;
    tick();
    park();
    expect_now(pk(0, 0, 0, 0, 0, 0, 1'b0), "pre_latch");

    // Triangle A, counter-clockwise: A=(40,-40,0), B=(0,50,-50)
    run_frame(1'b1, 10, 10, 10, 50, 60, 10, pk(-400, 2900, -500, 10, 50, 10, 1'b0), "setup_a");
    do_step(479);
    expect_now(pk(-400, 2900, -500, 10, 50, 10, 1'b0), "no_step_479");
    do_step(524);
    expect_now(pk(-400, 2850, -450, 10, 50, 10, 1'b0), "step_524");
    do_step(0);
    expect_now(pk(-400, 2800, -400, 10, 50, 10, 1'b0), "step_0");
    for (int n = 1; n <= 3; n++) begin
      do_step(n);
      expect_now(pk(-400, 2900 - 50 * (n + 2), -500 + 50 * (n + 2), 10, 50, 10, 1'b0),
                 $sformatf("step_%0d", n));
    end

    // vtx_valid low: reuses the shadowed triangle A
    run_frame(1'b0, 100, 7, -30, 200, 5, 5, pk(-400, 2900, -500, 10, 50, 10, 1'b0), "rerun_a");

    // Reset during the multiply phase aborts the setup
    latch_start(1'b1, -100, 200, 300, -50, 500, 400);
    repeat (30) tick();
    reset = 1'b1;
    tick();
    tick();
    park();
    expect_now(pk(0, 0, 0, 0, 0, 0, 1'b0), "reset_mid_mul");
    reset = 1'b0;
    tick();

`ifdef EDGE_SETUP_CULL_EN
    eb   = pk(-1, -1, -1, 0, 0, 0, 1'b0);
    eb_s = eb;
    ed   = pk(-1, -1, -1, 0, 0, 0, 1'b0);
    ed_s = ed;
`else
    eb   = pk(500, -2900, 400, 10, 10, 50, 1'b0);
    eb_s = pk(450, -2850, 400, 10, 10, 50, 1'b0);
    ed   = pk(55000, -145000, -140000, 200, -50, 400, 1'b0);
    ed_s = pk(54600, -145200, -139400, 200, -50, 400, 1'b0);
`endif
    // Triangle B, clockwise
    run_frame(1'b1, 10, 10, 60, 10, 10, 50, eb, "setup_b");
    do_step(524);
    expect_now(eb_s, "step_b");
    // Triangle D, negative coordinates and large products, clockwise
    run_frame(1'b1, -100, 200, 300, -50, 500, 400, ed, "setup_d");
    do_step(524);
    expect_now(ed_s, "step_d");

    done_req = 1'b1;
    tick();
    tick();
  end

  // ---------------- monitor ----------------
  task automatic check_pop(input string src);
    logic [120:0] act, e;
    string n;
    act = {e0_init_t1, e1_init_t1, e2_init_t1, y_screen_v0, y_screen_v1, y_screen_v2, setup_busy};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: output with no expectation queued, actual=%h", src, act);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: actual=%h required=%h", n, act, e);
      end
    end
  endtask

  initial begin
    logic busy_prev;
    int   busy_len;
    busy_prev = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (setup_busy) busy_len++;
      if (busy_prev && !setup_busy) begin
        if (!reset) begin
          total++;
          if (busy_len != EXP_BUSY) begin
            bad++;
            $display("FAIL busy_len: actual=%0d required=%0d", busy_len, EXP_BUSY);
          end
          check_pop("setup");
        end
        busy_len = 0;
      end
      if (chk_req) check_pop("sample");
      if (to_req) begin
        total++;
        bad++;
        $display("FAIL setup_timeout: setup_busy still high after 300 cycles, required low");
      end
      if (done_req) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      busy_prev = setup_busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
